// File: rtl/sysref_timebase_pkg.sv
// Shared types for the SYSREF-aligned timebase.
//   tb_state_t  : timebase sequencing states
//   trig_mode_t : per-channel trigger mode encoding (11 is treated as off)
//   sat_inc8    : saturating increment for the SYSREF edge counter
package sysref_timebase_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2
   } tb_state_t;

   typedef enum logic [1:0] {
      TRIG_OFF      = 2'd0,
      TRIG_ONESHOT  = 2'd1,
      TRIG_PERIODIC = 2'd2
   } trig_mode_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/sysref_timebase_trig_chan.sv
// One programmable time-trigger channel.
//   clk, aresetn        : clock, async active-low reset
//   clkcnt              : selected timebase count used for the compare
//   disarm              : clears enable, trig and trig_stb
//   trig_load           : latch trig_time/trig_period/trig_mode, clear trig
//   trig_mode           : 00 off, 01 oneshot, 10 periodic
//   trig_time           : absolute fire count
//   trig_period         : reload increment in periodic mode (0 = oneshot)
//   trig                : level, high once the channel has fired
//   trig_stb            : one-cycle pulse per fire
module timebase_trig_chan
   import sysref_timebase_pkg::*;
#(
   parameter int CNTWIDTH = 64,
   parameter int PERWIDTH = 32
) (
   input  logic                clk,
   input  logic                aresetn,
   input  logic [CNTWIDTH-1:0] clkcnt,
   input  logic                disarm,
   input  logic                trig_load,
   input  logic [1:0]          trig_mode,
   input  logic [CNTWIDTH-1:0] trig_time,
   input  logic [PERWIDTH-1:0] trig_period,
   output logic                trig,
   output logic                trig_stb
);

   logic                en_q;
   logic                periodic_q;
   logic                trig_q;
   logic                stb_q;
   logic [CNTWIDTH-1:0] target_q;
   logic [PERWIDTH-1:0] period_q;
   logic                fire;
   logic                load_en;

   assign fire    = en_q & (clkcnt >= target_q);
   assign load_en = (trig_mode == TRIG_ONESHOT) || (trig_mode == TRIG_PERIODIC);

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         en_q       <= 1'b0;
         periodic_q <= 1'b0;
         trig_q     <= 1'b0;
         stb_q      <= 1'b0;
         target_q   <= '0;
         period_q   <= '0;
      end else begin
         stb_q <= 1'b0;
         if (disarm) begin
            en_q   <= 1'b0;
            trig_q <= 1'b0;
         end else if (trig_load) begin
            // a load in the same cycle as a fire swallows the strobe
            target_q   <= trig_time;
            period_q   <= trig_period;
            periodic_q <= (trig_mode == TRIG_PERIODIC);
            en_q       <= load_en;
            trig_q     <= 1'b0;
         end else if (fire) begin
            stb_q  <= 1'b1;
            trig_q <= 1'b1;
            if (periodic_q && (period_q != '0)) begin
               target_q <= target_q + CNTWIDTH'(period_q);
            end else begin
               en_q <= 1'b0;
            end
         end
      end
   end

   assign trig     = trig_q;
   assign trig_stb = stb_q;

endmodule

// File: rtl/sysref_timebase.sv
// SYSREF-aligned global timebase with NTRIG time-triggers.
//   clk, aresetn : DSP clock, async active-low reset
//   sysref       : raw SYSREF, asynchronous to clk
//   arm, disarm  : sequencing pulses (disarm wins)
//   corr, corr_sw: offset added to the raw count, output select
//   trig_*       : per-channel load/mode/time/period
//   running      : timebase counting
//   sysref_cnt   : SYSREF edges since arm (saturating)
//   clkcnt_raw   : raw counter; clkcnt: selected count
//   trig, trig_stb : per-channel fired level and fire pulse
//
// state | meaning
// IDLE  | counter held at 0, waiting for arm
// ARMED | counting SYSREF rising edges up to SYSREF_ARM
// RUN   | counter increments every cycle
module sysref_timebase
   import sysref_timebase_pkg::*;
#(
   parameter int CNTWIDTH    = 64,
   parameter int NTRIG       = 4,
   parameter int SYSREF_ARM  = 4,
   parameter int SYNC_STAGES = 2,
   parameter int PERWIDTH    = 32
) (
   input  logic                      clk,
   input  logic                      aresetn,
   input  logic                      sysref,
   input  logic                      arm,
   input  logic                      disarm,
   input  logic [CNTWIDTH-1:0]       corr,
   input  logic                      corr_sw,
   input  logic [NTRIG-1:0]          trig_load,
   input  logic [2*NTRIG-1:0]        trig_mode,
   input  logic [CNTWIDTH*NTRIG-1:0] trig_time,
   input  logic [PERWIDTH*NTRIG-1:0] trig_period,
   output logic                      running,
   output logic [7:0]                sysref_cnt,
   output logic [CNTWIDTH-1:0]       clkcnt_raw,
   output logic [CNTWIDTH-1:0]       clkcnt,
   output logic [NTRIG-1:0]          trig,
   output logic [NTRIG-1:0]          trig_stb
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sref_prev_q;
   logic                   sref_rise_q;
   tb_state_t              state_q;
   logic                   running_q;
   logic [7:0]             cnt_q;
   logic [CNTWIDTH-1:0]    raw_q;
   logic [CNTWIDTH-1:0]    raw_d;
   logic [CNTWIDTH-1:0]    corr_q;

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         sync_q      <= '0;
         sref_prev_q <= 1'b0;
         sref_rise_q <= 1'b0;
      end else begin
         sync_q      <= {sync_q[SYNC_STAGES-2:0], sysref};
         sref_prev_q <= sync_q[SYNC_STAGES-1];
         sref_rise_q <= sync_q[SYNC_STAGES-1] & ~sref_prev_q;
      end
   end

   always_comb begin
      raw_d = raw_q;
      if (disarm) begin
         raw_d = '0;
      end else if (state_q == RUN) begin
         raw_d = raw_q + CNTWIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= IDLE;
         running_q <= 1'b0;
         cnt_q     <= '0;
         raw_q     <= '0;
      end else begin
         raw_q <= raw_d;
         if (disarm) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (arm) begin
                     state_q <= ARMED;
                     cnt_q   <= '0;
                  end
               end
               ARMED: begin
                  if (sref_rise_q) begin
                     cnt_q <= sat_inc8(cnt_q);
                     if (cnt_q == 8'(SYSREF_ARM - 1)) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                     end
                  end
               end
               RUN: begin
                  if (sref_rise_q) begin
                     cnt_q <= sat_inc8(cnt_q);
                  end
               end
               default: begin
                  state_q   <= IDLE;
                  running_q <= 1'b0;
               end
            endcase
         end
      end
   end

   // Sum built from the next raw value so the corrected count lines up with
   // clkcnt_raw; a change on corr shows up one cycle later.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         corr_q <= '0;
      end else begin
         corr_q <= raw_d + corr;
      end
   end

   assign running    = running_q;
   assign sysref_cnt = cnt_q;
   assign clkcnt_raw = raw_q;
   assign clkcnt     = corr_sw ? corr_q : raw_q;

   for (genvar k = 0; k < NTRIG; k++) begin : g_chan
      timebase_trig_chan #(
         .CNTWIDTH (CNTWIDTH),
         .PERWIDTH (PERWIDTH)
      ) u_chan (
         .clk         (clk),
         .aresetn     (aresetn),
         .clkcnt      (clkcnt),
         .disarm      (disarm),
         .trig_load   (trig_load[k]),
         .trig_mode   (trig_mode[2*k +: 2]),
         .trig_time   (trig_time[k*CNTWIDTH +: CNTWIDTH]),
         .trig_period (trig_period[k*PERWIDTH +: PERWIDTH]),
         .trig        (trig[k]),
         .trig_stb    (trig_stb[k])
      );
   end

endmodule

// File: tb/tb_sysref_timebase.sv
module tb_sysref_timebase;

   localparam int CW   = 64;
   localparam int NT   = 4;
   localparam int ARMN = 4;
   localparam int SS   = 2;
   localparam int PW   = 32;

   logic             clk       = 1'b0;
   logic             aresetn   = 1'b0;
   logic             sysref    = 1'b0;
   logic             arm       = 1'b0;
   logic             disarm    = 1'b0;
   logic [CW-1:0]    corr      = '0;
   logic             corr_sw   = 1'b0;
   logic [NT-1:0]    trig_load = '0;
   logic [2*NT-1:0]  trig_mode = '0;
   logic [CW*NT-1:0] trig_time = '0;
   logic [PW*NT-1:0] trig_period = '0;
   logic             running;
   logic [7:0]       sysref_cnt;
   logic [CW-1:0]    clkcnt_raw;
   logic [CW-1:0]    clkcnt;
   logic [NT-1:0]    trig;
   logic [NT-1:0]    trig_stb;

   int n_chk  = 0;
   int n_fail = 0;

   // reference model: phase 0 idle, 1 armed, 2 run; raw is edges since run entry
   int            m_phase = 0;
   int            m_cnt   = 0;
   longint        edge_no = 0;
   longint        run_edge = 0;
   logic [CW-1:0] m_corr = '0;
   bit            m_hist [SS+2];
   bit            m_en   [NT];
   bit            m_per  [NT];
   bit            m_trig [NT];
   bit            m_stb  [NT];
   logic [CW-1:0] m_tgt  [NT];
   logic [PW-1:0] m_prd  [NT];

   logic [CW-1:0] t_col;
   int            cnt_extra;

   sysref_timebase u_dut (
      .clk         (clk),
      .aresetn     (aresetn),
      .sysref      (sysref),
      .arm         (arm),
      .disarm      (disarm),
      .corr        (corr),
      .corr_sw     (corr_sw),
      .trig_load   (trig_load),
      .trig_mode   (trig_mode),
      .trig_time   (trig_time),
      .trig_period (trig_period),
      .running     (running),
      .sysref_cnt  (sysref_cnt),
      .clkcnt_raw  (clkcnt_raw),
      .clkcnt      (clkcnt),
      .trig        (trig),
      .trig_stb    (trig_stb)
   );

   always #5 clk = ~clk;

   function automatic logic [CW-1:0] exp_raw();
      return (m_phase == 2) ? CW'(edge_no - run_edge) : '0;
   endfunction

   task automatic model_reset();
      m_phase = 0;
      m_cnt   = 0;
      m_corr  = '0;
      for (int i = 0; i < SS+2; i++) m_hist[i] = 1'b0;
      for (int k = 0; k < NT; k++) begin
         m_en[k] = 0; m_per[k] = 0; m_trig[k] = 0; m_stb[k] = 0;
         m_tgt[k] = '0; m_prd[k] = '0;
      end
   endtask

   task automatic model_step();
      logic [CW-1:0] pre_raw;
      logic [CW-1:0] cc;
      bit            rise;
      pre_raw = exp_raw();
      cc      = corr_sw ? m_corr : pre_raw;
      // pin level reaches the sequencer SS+1 edges after it is sampled
      rise    = m_hist[SS] && !m_hist[SS+1];
      for (int i = SS+1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = sysref;
      edge_no++;
      if (disarm) begin
         m_phase = 0;
      end else if (m_phase == 0) begin
         if (arm) begin m_phase = 1; m_cnt = 0; end
      end else if (m_phase == 1) begin
         if (rise) begin
            m_cnt++;
            if (m_cnt == ARMN) begin m_phase = 2; run_edge = edge_no; end
         end
      end else begin
         if (rise && m_cnt < 255) m_cnt++;
      end
      for (int k = 0; k < NT; k++) begin
         m_stb[k] = 0;
         if (disarm) begin
            m_en[k] = 0; m_trig[k] = 0;
         end else if (trig_load[k]) begin
            m_tgt[k]  = trig_time[k*CW +: CW];
            m_prd[k]  = trig_period[k*PW +: PW];
            m_per[k]  = (trig_mode[2*k +: 2] == 2'b10);
            m_en[k]   = (trig_mode[2*k +: 2] == 2'b01) || (trig_mode[2*k +: 2] == 2'b10);
            m_trig[k] = 0;
         end else if (m_en[k] && cc >= m_tgt[k]) begin
            m_stb[k]  = 1;
            m_trig[k] = 1;
            if (m_per[k] && m_prd[k] != 0) m_tgt[k] = m_tgt[k] + CW'(m_prd[k]);
            else m_en[k] = 0;
         end
      end
      m_corr = exp_raw() + corr;
   endtask

   always @(posedge clk or negedge aresetn) begin
      if (!aresetn) model_reset();
      else model_step();
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      logic [NT-1:0] et;
      logic [NT-1:0] es;
      @(negedge clk);
      for (int k = 0; k < NT; k++) begin
         et[k] = m_trig[k];
         es[k] = m_stb[k];
      end
      chk("running", 64'(running), 64'(m_phase == 2));
      chk("sysref_cnt", 64'(sysref_cnt), 64'(8'(m_cnt)));
      chk("clkcnt_raw", clkcnt_raw, exp_raw());
      chk("clkcnt", clkcnt, corr_sw ? m_corr : exp_raw());
      chk("trig", 64'(trig), 64'(et));
      chk("trig_stb", 64'(trig_stb), 64'(es));
   endtask

   task automatic load(input int k, input logic [1:0] mode, input logic [CW-1:0] t,
                       input logic [PW-1:0] p);
      trig_load[k]           = 1'b1;
      trig_mode[2*k +: 2]    = mode;
      trig_time[k*CW +: CW]  = t;
      trig_period[k*PW +: PW] = p;
      cyc();
      trig_load = '0;
   endtask

   task automatic sysref_pulses(input int n);
      repeat (n) begin
         sysref = 1'b1;
         repeat (4) cyc();
         sysref = 1'b0;
         repeat (4) cyc();
      end
   endtask

   task automatic wait_stb(input int k);
      for (int i = 0; i < 300; i++) begin
         cyc();
         if (trig_stb[k]) break;
      end
      chk($sformatf("stb%0d_seen", k), 64'(trig_stb[k]), 64'd1);
   endtask

   initial begin
      int sr_left;
      logic [CW-1:0] base;

      repeat (3) cyc();
      chk("rst_running", 64'(running), 0);
      chk("rst_raw", clkcnt_raw, 0);
      chk("rst_trig", 64'(trig), 0);
      aresetn = 1'b1;
      cyc();

      // edge gating
      arm = 1'b1; cyc(); arm = 1'b0;
      sysref_pulses(3);
      chk("gate_not_yet", 64'(running), 0);
      chk("gate_raw0", clkcnt_raw, 0);
      sysref_pulses(1);
      chk("gate_running", 64'(running), 1);
      chk("gate_cnt", 64'(sysref_cnt), 4);
      chk("gate_raw", clkcnt_raw, 4);

      // correction
      corr = 64'd1000; corr_sw = 1'b1; cyc();
      chk("corr_ofs", clkcnt - clkcnt_raw, 64'd1000);
      corr = '1; cyc();
      chk("corr_wrap", clkcnt - clkcnt_raw, 64'hFFFF_FFFF_FFFF_FFFF);
      corr_sw = 1'b0; corr = '0; cyc();

      // oneshot
      load(0, 2'b01, 64'd50, '0);
      wait_stb(0);
      chk("os_fire_at", clkcnt_raw, 64'd51);
      cyc();
      chk("os_single", 64'(trig_stb[0]), 0);
      chk("os_level", 64'(trig[0]), 1);
      load(0, 2'b01, 64'd80, '0);
      chk("os_reload_clr", 64'(trig[0]), 0);
      wait_stb(0);
      chk("os_refire_at", clkcnt_raw, 64'd81);

      // periodic
      load(1, 2'b10, 64'd100, 32'd25);
      for (int j = 0; j < 4; j++) begin
         wait_stb(1);
         chk($sformatf("per_fire%0d", j), clkcnt_raw, 64'(101 + 25*j));
      end
      load(1, 2'b10, 64'd200, 32'd0);
      wait_stb(1);
      chk("per0_fire", clkcnt_raw, 64'd201);
      cnt_extra = 0;
      repeat (40) begin
         cyc();
         cnt_extra += int'(trig_stb[1]);
      end
      chk("per0_extra", 64'(cnt_extra), 0);

      // load colliding with a fire
      t_col = exp_raw() + 64'd10;
      load(2, 2'b01, t_col, '0);
      for (int i = 0; i < 50 && exp_raw() != t_col; i++) cyc();
      load(2, 2'b01, t_col + 64'd20, '0);
      chk("col_no_stb", 64'(trig_stb[2]), 0);
      chk("col_no_trig", 64'(trig[2]), 0);
      wait_stb(2);
      chk("col_new_target", clkcnt_raw, t_col + 64'd21);

      // disarm beats arm
      disarm = 1'b1; arm = 1'b1; cyc();
      disarm = 1'b0; arm = 1'b0;
      chk("da_running", 64'(running), 0);
      chk("da_raw", clkcnt_raw, 0);
      sysref_pulses(5);
      chk("da_idle", 64'(running), 0);

      // async reset mid-run
      arm = 1'b1; cyc(); arm = 1'b0;
      sysref_pulses(4);
      load(1, 2'b10, exp_raw() + 64'd5, 32'd3);
      load(3, 2'b10, exp_raw() + 64'd2, 32'd2);
      repeat (20) cyc();
      chk("pre_rst_trig", 64'(trig[1] & trig[3]), 1);
      #1 aresetn = 1'b0;
      #1;
      chk("arst_running", 64'(running), 0);
      chk("arst_cnt", 64'(sysref_cnt), 0);
      chk("arst_raw", clkcnt_raw, 0);
      chk("arst_clkcnt", clkcnt, 0);
      chk("arst_trig", 64'(trig), 0);
      chk("arst_stb", 64'(trig_stb), 0);
      #2 aresetn = 1'b1;
      cyc();
      arm = 1'b1; cyc(); arm = 1'b0;
      sysref_pulses(4);
      chk("rearm_raw", clkcnt_raw, 4);
      chk("rearm_trig", 64'(trig), 0);

      // randomized traffic against the model
      sr_left = 3;
      for (int c = 0; c < 3000; c++) begin
         arm    = ($urandom_range(0, 39) == 0);
         disarm = ($urandom_range(0, 249) == 0);
         sr_left--;
         if (sr_left == 0) begin
            sysref  = ~sysref;
            sr_left = $urandom_range(2, 6);
         end
         if ($urandom_range(0, 49) == 0) corr_sw = ~corr_sw;
         if ($urandom_range(0, 99) == 0)
            corr = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : CW'($urandom_range(0, 500));
         trig_load = '0;
         for (int k = 0; k < NT; k++) begin
            if ($urandom_range(0, 29) == 0) begin
               base = corr_sw ? m_corr : exp_raw();
               trig_load[k] = 1'b1;
               trig_mode[2*k +: 2] = 2'($urandom_range(0, 3));
               trig_time[k*CW +: CW] = ($urandom_range(0, 9) == 0) ? '0
                                       : base + CW'($urandom_range(0, 80));
               trig_period[k*PW +: PW] = PW'($urandom_range(0, 15));
            end
         end
         cyc();
      end
      trig_load = '0; arm = 1'b0; disarm = 1'b0;
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
